// File: rtl/mbox_fifo.sv
// Mailbox byte FIFO: a DEPTH-entry array feeding a registered output stage
// for the WOU transmitter, with occupancy flags and a sticky overflow flag.
module mbox_fifo #(
    parameter int WOU_DW       = 8,
    parameter int AW           = 6,
    parameter int AFULL_MARGIN = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mbox_wr_i,
    input  logic [WOU_DW-1:0] mbox_di_i,
    output logic              mbox_full_o,
    output logic              mbox_afull_o,
    output logic              tx_valid_o,
    output logic [WOU_DW-1:0] tx_data_o,
    input  logic              tx_ready_i,
    output logic [AW:0]       mbox_cnt_o,
    output logic              mbox_ovf_o,
    input  logic              clr_ovf_i
);

    localparam int          DEPTH       = 1 << AW;
    localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL_C = (AW+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [AW:0] CNT_ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO_C  = (AW+1)'(0);

    logic [WOU_DW-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       cnt_r;
    logic              valid_r;
    logic [WOU_DW-1:0] data_r;
    logic              full_r;
    logic              afull_r;
    logic              ovf_r;

    logic              wr_acc_s;
    logic              xfer_s;
    logic [AW:0]       arr_cnt_s;
    logic              arr_ne_s;
    logic              load_s;
    logic [AW:0]       cnt_nxt_s;
    logic              valid_nxt_s;
    logic              full_nxt_s;
    logic              afull_nxt_s;
    logic              ovf_nxt_s;

    // Handshake decode and next-state computation for count, valid and flags.
    always_comb begin
        wr_acc_s    = mbox_wr_i & ~full_r;
        xfer_s      = valid_r & tx_ready_i;
        // The output register is part of the count, so the array holds cnt - valid.
        arr_cnt_s   = cnt_r - {{AW{1'b0}}, valid_r};
        arr_ne_s    = (arr_cnt_s != CNT_ZERO_C);
        load_s      = arr_ne_s & (xfer_s | ~valid_r);
        cnt_nxt_s   = cnt_r;
        valid_nxt_s = valid_r;
        ovf_nxt_s   = ovf_r;

        case ({wr_acc_s, xfer_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE_C;
            default: cnt_nxt_s = cnt_r;
        endcase

        if (load_s) begin
            valid_nxt_s = 1'b1;
        end else if (xfer_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        // A discarded write outranks a clear in the same cycle.
        if (mbox_wr_i && full_r) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        full_nxt_s  = (cnt_nxt_s == DEPTH_C);
        afull_nxt_s = (cnt_nxt_s >= AFULL_LVL_C);
    end

    // Array write port; contents are not reset, only the pointers are.
    always_ff @(posedge wb_clk_i) begin
        if (wr_acc_s && !wb_rst_i) begin
            mem_r[wr_ptr_r] <= mbox_di_i;
        end
    end

    // Pointer, count, output register and flag state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= CNT_ZERO_C;
            valid_r  <= 1'b0;
            data_r   <= {WOU_DW{1'b0}};
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (load_s) begin
                data_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            cnt_r   <= cnt_nxt_s;
            valid_r <= valid_nxt_s;
            full_r  <= full_nxt_s;
            afull_r <= afull_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign mbox_full_o  = full_r;
    assign mbox_afull_o = afull_r;
    assign tx_valid_o   = valid_r;
    assign tx_data_o    = data_r;
    assign mbox_cnt_o   = cnt_r;
    assign mbox_ovf_o   = ovf_r;

endmodule

// File: tb/tb_mbox_fifo.sv
// Directed self-checking bench for mbox_fifo with AW=4, DEPTH=16, AFULL_MARGIN=4.
module tb_mbox_fifo;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       mbox_wr_i = 1'b0;
    logic [7:0] mbox_di_i = 8'h00;
    logic       mbox_full_o;
    logic       mbox_afull_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_i = 1'b0;
    logic [4:0] mbox_cnt_o;
    logic       mbox_ovf_o;
    logic       clr_ovf_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    mbox_fifo #(.WOU_DW(8), .AW(4), .AFULL_MARGIN(4)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .mbox_wr_i   (mbox_wr_i),
        .mbox_di_i   (mbox_di_i),
        .mbox_full_o (mbox_full_o),
        .mbox_afull_o(mbox_afull_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .mbox_cnt_o  (mbox_cnt_o),
        .mbox_ovf_o  (mbox_ovf_o),
        .clr_ovf_i   (clr_ovf_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        mbox_wr_i = 1'b0; tx_ready_i = 1'b0; clr_ovf_i = 1'b0;
        wb_rst_i = 1'b1;
        tick(); tick();
        wb_rst_i = 1'b0;
    endtask

    // Drain n bytes expecting first..first+n-1, with a bounded wait for each.
    task automatic drain_check(input string name, input logic [7:0] first, input int n);
        logic [7:0] exp;
        int waited;
        for (int i = 0; i < n; i++) begin
            exp = first + 8'(i);
            waited = 0;
            while (!tx_valid_o && waited < 10) begin
                tick();
                waited++;
            end
            tests_run++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== exp) begin
                tests_failed++;
                $display("FAIL %s byte %0d: got valid=%b data=%h, expected valid=1 data=%h",
                         name, i, tx_valid_o, tx_data_o, exp);
            end
            tx_ready_i = 1'b1;
            tick();
            tx_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({mbox_cnt_o, tx_valid_o, tx_data_o, mbox_ovf_o, mbox_full_o, mbox_afull_o}
            !== {5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: cnt=%0d valid=%b data=%h ovf=%b full=%b afull=%b, expected all 0",
                     mbox_cnt_o, tx_valid_o, tx_data_o, mbox_ovf_o, mbox_full_o, mbox_afull_o);
        end
    endtask

    task automatic test_latency();
        do_reset();
        mbox_wr_i = 1'b1; mbox_di_i = 8'h11;
        tick();
        mbox_wr_i = 1'b0;
        tests_run++;
        if (tx_valid_o !== 1'b0 || mbox_cnt_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL latency_c1: valid=%b cnt=%0d, expected valid=0 cnt=1", tx_valid_o, mbox_cnt_o);
        end
        tick();
        tests_run++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h11) begin
            tests_failed++;
            $display("FAIL latency_c2: valid=%b data=%h, expected valid=1 data=11", tx_valid_o, tx_data_o);
        end
        tick();
        tests_run++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h11 || mbox_cnt_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL hold_c3: valid=%b data=%h cnt=%0d, expected 1 11 1", tx_valid_o, tx_data_o, mbox_cnt_o);
        end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        tests_run++;
        if (tx_valid_o !== 1'b0 || mbox_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL latency_c4: valid=%b cnt=%0d, expected valid=0 cnt=0", tx_valid_o, mbox_cnt_o);
        end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        tests_run++;
        if (tx_valid_o !== 1'b0 || mbox_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL ready_when_empty: valid=%b cnt=%0d, expected 0 0", tx_valid_o, mbox_cnt_o);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mbox_wr_i = 1'b1; mbox_di_i = 8'(i);
            tick();
            tests_run++;
            if (mbox_cnt_o !== 5'(i + 1) || mbox_afull_o !== (i + 1 >= 12) || mbox_full_o !== (i + 1 == 16)) begin
                tests_failed++;
                $display("FAIL fill_%0d: cnt=%0d afull=%b full=%b, expected cnt=%0d afull=%b full=%b",
                         i, mbox_cnt_o, mbox_afull_o, mbox_full_o, i + 1, (i + 1 >= 12), (i + 1 == 16));
            end
        end
        mbox_di_i = 8'hAA;
        tick();
        tests_run++;
        if (mbox_cnt_o !== 5'd16 || mbox_ovf_o !== 1'b1 || mbox_full_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: cnt=%0d ovf=%b full=%b, expected 16 1 1", mbox_cnt_o, mbox_ovf_o, mbox_full_o);
        end
        // Write plus clear in the same cycle: the set wins.
        clr_ovf_i = 1'b1;
        tick();
        tests_run++;
        if (mbox_ovf_o !== 1'b1 || mbox_cnt_o !== 5'd16) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: ovf=%b cnt=%0d, expected ovf=1 cnt=16", mbox_ovf_o, mbox_cnt_o);
        end
        mbox_wr_i = 1'b0;
        tick();
        clr_ovf_i = 1'b0;
        tests_run++;
        if (mbox_ovf_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", mbox_ovf_o);
        end
        drain_check("fill_drain", 8'h00, 16);
        tests_run++;
        if (mbox_cnt_o !== 5'd0 || tx_valid_o !== 1'b0 || mbox_full_o !== 1'b0 || mbox_afull_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drained: cnt=%0d valid=%b full=%b afull=%b, expected all 0",
                     mbox_cnt_o, tx_valid_o, mbox_full_o, mbox_afull_o);
        end
    endtask

    task automatic test_simul_rw();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mbox_wr_i = 1'b1; mbox_di_i = 8'h50 + 8'(i);
            tick();
        end
        mbox_wr_i = 1'b0;
        tick();
        tests_run++;
        if (mbox_cnt_o !== 5'd5 || tx_valid_o !== 1'b1 || tx_data_o !== 8'h50) begin
            tests_failed++;
            $display("FAIL simul_pre: cnt=%0d valid=%b data=%h, expected 5 1 50", mbox_cnt_o, tx_valid_o, tx_data_o);
        end
        mbox_wr_i = 1'b1; mbox_di_i = 8'h55; tx_ready_i = 1'b1;
        tick();
        mbox_wr_i = 1'b0; tx_ready_i = 1'b0;
        tests_run++;
        if (mbox_cnt_o !== 5'd5) begin
            tests_failed++;
            $display("FAIL simul_cnt: cnt=%0d, expected 5", mbox_cnt_o);
        end
        drain_check("simul_drain", 8'h51, 5);
    endtask

    task automatic test_back_to_back();
        int wr_n = 0;
        int rx_n = 0;
        int cyc = 0;
        do_reset();
        while (rx_n < 40 && cyc < 400) begin
            tx_ready_i = (cyc % 2 == 0);
            if (wr_n < 40 && !mbox_full_o) begin
                mbox_wr_i = 1'b1; mbox_di_i = 8'(wr_n);
                wr_n++;
            end else begin
                mbox_wr_i = 1'b0;
            end
            if (tx_valid_o && tx_ready_i) begin
                tests_run++;
                if (tx_data_o !== 8'(rx_n)) begin
                    tests_failed++;
                    $display("FAIL stream_byte_%0d: got %h, expected %h", rx_n, tx_data_o, 8'(rx_n));
                end
                rx_n++;
            end
            tick();
            cyc++;
        end
        mbox_wr_i = 1'b0; tx_ready_i = 1'b0;
        tests_run++;
        if (rx_n != 40 || mbox_ovf_o !== 1'b0 || mbox_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL stream_done: received=%0d ovf=%b cnt=%0d, expected 40 0 0", rx_n, mbox_ovf_o, mbox_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mbox_wr_i = 1'b1; mbox_di_i = 8'h30 + 8'(i);
            tick();
        end
        mbox_wr_i = 1'b0;
        tick();
        tests_run++;
        if (mbox_cnt_o !== 5'd9 || tx_valid_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: cnt=%0d valid=%b, expected 9 1", mbox_cnt_o, tx_valid_o);
        end
        wb_rst_i = 1'b1; mbox_wr_i = 1'b1; mbox_di_i = 8'hEE;
        tick();
        wb_rst_i = 1'b0; mbox_wr_i = 1'b0;
        tests_run++;
        if ({mbox_cnt_o, tx_valid_o, tx_data_o, mbox_ovf_o, mbox_full_o, mbox_afull_o}
            !== {5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midrst_state: cnt=%0d valid=%b data=%h ovf=%b full=%b afull=%b, expected all 0",
                     mbox_cnt_o, tx_valid_o, tx_data_o, mbox_ovf_o, mbox_full_o, mbox_afull_o);
        end
        tick(); tick();
        tests_run++;
        if (mbox_cnt_o !== 5'd0 || tx_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_wr_ignored: cnt=%0d valid=%b, expected 0 0", mbox_cnt_o, tx_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_simul_rw();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mbox_fifo.md
MBOX_FIFO -- requirements
Module: mbox_fifo

Interface
REQ-001 Parameter WOU_DW, default 8: byte width of mailbox data.
REQ-002 Parameter AW, default 6: address width; FIFO capacity DEPTH = 2^AW bytes.
REQ-003 Parameter AFULL_MARGIN, default 4: almost-full asserts at DEPTH-AFULL_MARGIN bytes; SHALL satisfy 1 <= AFULL_MARGIN < DEPTH.
REQ-004 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-005 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-006 mbox_wr_i  in  1  write strobe from mailbox writer, one byte per cycle.
REQ-007 mbox_di_i  in  WOU_DW  write data, least-significant byte of word first.
REQ-008 mbox_full_o  out  1  FIFO holds DEPTH bytes.
REQ-009 mbox_afull_o  out  1  FIFO holds >= DEPTH-AFULL_MARGIN bytes.
REQ-010 tx_valid_o  out  1  tx_data_o holds a valid byte for the WOU transmitter.
REQ-011 tx_data_o  out  WOU_DW  head-of-FIFO byte, registered.
REQ-012 tx_ready_i  in  1  transmitter accepts tx_data_o this cycle.
REQ-013 mbox_cnt_o  out  AW+1  bytes held, including the output register.
REQ-014 mbox_ovf_o  out  1  sticky overflow flag.
REQ-015 clr_ovf_i  in  1  clears mbox_ovf_o.

Function
REQ-016 Storage SHALL be a DEPTH-entry array plus one output register (tx_data_o); DEPTH bounds total occupancy mbox_cnt_o, output register included.
REQ-017 Write accepted iff mbox_wr_i=1 and mbox_full_o=0 in that cycle; accepted byte written at wr_ptr, which advances modulo DEPTH.
REQ-018 mbox_wr_i=1 while mbox_full_o=1: byte discarded, no state change except mbox_ovf_o<=1; no bypass even if a read occurs the same cycle.
REQ-019 Transfer occurs iff tx_valid_o=1 and tx_ready_i=1; tx_data_o then reloads from array head the same edge if the array is non-empty, else tx_valid_o<=0.
REQ-020 With tx_valid_o=0 and the array non-empty, the output register SHALL load the array head on the next edge (rd_ptr advances modulo DEPTH).
REQ-021 Latency: byte written to an empty FIFO in cycle N SHALL appear with tx_valid_o=1 in cycle N+2.
REQ-022 tx_data_o and tx_valid_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-023 mbox_cnt_o: +1 on accepted write, -1 on transfer, unchanged when both or neither occur in the same cycle.
REQ-024 mbox_full_o = (mbox_cnt_o == DEPTH); mbox_afull_o = (mbox_cnt_o >= DEPTH-AFULL_MARGIN); both decoded from registered count only, no combinational path from mbox_wr_i or tx_ready_i.
REQ-025 Byte order at tx_data_o SHALL equal acceptance order across pointer wrap-around.
REQ-026 mbox_ovf_o: set on a discarded write, cleared by clr_ovf_i=1; set wins when both occur in the same cycle.
REQ-027 tx_ready_i with tx_valid_o=0 SHALL have no effect.

Reset
REQ-028 wb_rst_i=1 at an edge SHALL force wr_ptr=0, rd_ptr=0, mbox_cnt_o=0, tx_valid_o=0, tx_data_o=0, mbox_ovf_o=0, mbox_full_o=0, mbox_afull_o=0.
REQ-029 Reset mid-operation SHALL discard all held bytes; writes in the reset cycle are ignored; array contents need no reset.

Verification (AW=4, DEPTH=16, AFULL_MARGIN=4)
REQ-030 Reset, tx_ready_i=0, write 0x11 in cycle 0 -> tx_valid_o=1, tx_data_o=0x11 from cycle 2; tx_ready_i=1 in cycle 3 -> tx_valid_o=0, mbox_cnt_o=0 in cycle 4.
REQ-031 tx_ready_i=0, write 0x00..0x0F -> mbox_afull_o=1 once cnt=12, mbox_full_o=1 at cnt=16; 17th write 0xAA dropped, mbox_ovf_o=1, cnt stays 16; drain yields 0x00..0x0F in order, no 0xAA.
REQ-032 cnt=5, mbox_wr_i=1 and valid transfer in same cycle -> cnt stays 5, order preserved.
REQ-033 Stream 40 bytes 0x00..0x27 with writes gated by mbox_full_o and tx_ready_i toggling 1,0 -> all 40 received in order across two wraps, mbox_ovf_o=0.
REQ-034 cnt=9, tx_valid_o=1, assert wb_rst_i one cycle -> next cycle cnt=0, tx_valid_o=0, tx_data_o=0, mbox_ovf_o=0, full/afull=0.
REQ-035 Full FIFO, write and clr_ovf_i=1 in same cycle with mbox_ovf_o=1 -> mbox_ovf_o stays 1; clr_ovf_i=1 alone next cycle -> mbox_ovf_o=0.
